// File: rtl/psinr_status_merge.sv
// Merges the combiner, PSINR calc and PSINR output status streams into one tagged,
// FIFO-buffered stream, with per-source saturating event counters and sticky errors.
module psinr_status_merge #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          arst_n,
    input  logic                          comb_status_tvalid,
    input  logic [11:0]                   comb_status_tdata,
    output logic                          comb_status_tready,
    input  logic                          psinr_calc_status_tvalid,
    input  logic [9:0]                    psinr_calc_status_tdata,
    output logic                          psinr_calc_status_tready,
    input  logic                          psinr_out_status_tvalid,
    input  logic [6:0]                    psinr_out_status_tdata,
    output logic                          psinr_out_status_tready,
    output logic                          m_status_tvalid,
    output logic [15:0]                   m_status_tdata,
    input  logic                          m_status_tready,
    input  logic                          clr,
    output logic [CNT_W-1:0]              cnt_comb,
    output logic [CNT_W-1:0]              cnt_calc,
    output logic [CNT_W-1:0]              cnt_out,
    output logic [2:0]                    err_sticky,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [2:0]       in_valid;
    logic [11:0]      in_data [3];
    logic [2:0]       in_ready;
    logic [2:0]       hs;
    logic [2:0]       err_bit;
    logic [2:0]       hold_valid;
    logic [11:0]      hold_data [3];
    logic [2:0]       grant;
    logic             gnt_any;
    logic [1:0]       gnt_idx;
    logic [1:0]       rr_ptr;
    logic [CNT_W-1:0] cnt [3];
    logic [2:0]       err;

    assign in_valid   = {psinr_out_status_tvalid, psinr_calc_status_tvalid, comb_status_tvalid};
    assign in_data[0] = comb_status_tdata;
    assign in_data[1] = {2'b00, psinr_calc_status_tdata};
    assign in_data[2] = {5'b00000, psinr_out_status_tdata};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_src
            assign in_ready[gi] = !hold_valid[gi] || grant[gi];
            assign hs[gi]       = in_valid[gi] && in_ready[gi];
            assign err_bit[gi]  = in_data[gi][0];
        end
    endgenerate

    assign comb_status_tready       = in_ready[0];
    assign psinr_calc_status_tready = in_ready[1];
    assign psinr_out_status_tready  = in_ready[2];
    assign cnt_comb   = cnt[0];
    assign cnt_calc   = cnt[1];
    assign cnt_out    = cnt[2];
    assign err_sticky = err;

    // Round-robin search from rr_ptr; space is judged on the registered level only.
    always_comb begin
        logic [2:0] sum;
        logic [1:0] idx;
        grant   = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        sum     = '0;
        idx     = '0;
        if (fifo_level < LW'(FIFO_DEPTH)) begin
            for (int k = 0; k < 3; k++) begin
                sum = {1'b0, rr_ptr} + 3'(k);
                idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : 2'(sum);
                if (!gnt_any && hold_valid[idx]) begin
                    grant[idx] = 1'b1;
                    gnt_any    = 1'b1;
                    gnt_idx    = idx;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            hold_valid <= '0;
            rr_ptr     <= '0;
            err        <= '0;
            for (int i = 0; i < 3; i++) begin
                hold_data[i] <= '0;
                cnt[i]       <= '0;
            end
        end else begin
            if (gnt_any)
                rr_ptr <= (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
            err <= (clr ? 3'b000 : err) | (hs & err_bit);
            for (int i = 0; i < 3; i++) begin
                if (hs[i]) begin
                    hold_valid[i] <= 1'b1;
                    hold_data[i]  <= in_data[i];
                end else if (grant[i]) begin
                    hold_valid[i] <= 1'b0;
                end
                if (clr)
                    cnt[i] <= hs[i] ? CNT_W'(1) : '0;
                else if (hs[i] && cnt[i] != CNT_MAX)
                    cnt[i] <= cnt[i] + CNT_W'(1);
            end
        end
    end

    logic            push;
    logic            pop;
    logic [15:0]     push_word;
    logic [15:0]     mem [FIFO_DEPTH];
    logic [15:0]     head;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   rd_ptr_next;
    logic [LW-1:0]   level_after_pop;
    logic [LW-1:0]   level_next;

    assign push            = gnt_any;
    assign pop             = m_status_tvalid && m_status_tready;
    assign push_word       = {gnt_idx, 2'b00, hold_data[gnt_idx]};
    assign level_after_pop = fifo_level - LW'(pop);
    assign level_next      = level_after_pop + LW'(push);
    assign rd_ptr_next     = rd_ptr + AW'(pop);
    assign m_status_tvalid = (fifo_level != '0);
    assign m_status_tdata  = head;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_word;
    end

    // The head register tracks the oldest entry; a push into an otherwise empty
    // buffer bypasses the array since that write lands on the same edge.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            head       <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            rd_ptr     <= rd_ptr_next;
            fifo_level <= level_next;
            if (level_next == '0)
                head <= '0;
            else if (push && level_after_pop == '0)
                head <= push_word;
            else
                head <= mem[rd_ptr_next];
        end
    end
endmodule

// File: tb/tb_psinr_status_merge.sv
// Randomized self-checking bench for psinr_status_merge against a queue/count model.
module tb_psinr_status_merge;
    localparam int FIFO_DEPTH = 8;
    localparam int CNT_W      = 4;
    localparam int LW         = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_SAT    = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              arst_n = 1'b0;
    logic              comb_status_tvalid = 1'b0;
    logic [11:0]       comb_status_tdata = '0;
    logic              comb_status_tready;
    logic              psinr_calc_status_tvalid = 1'b0;
    logic [9:0]        psinr_calc_status_tdata = '0;
    logic              psinr_calc_status_tready;
    logic              psinr_out_status_tvalid = 1'b0;
    logic [6:0]        psinr_out_status_tdata = '0;
    logic              psinr_out_status_tready;
    logic              m_status_tvalid;
    logic [15:0]       m_status_tdata;
    logic              m_status_tready = 1'b0;
    logic              clr = 1'b0;
    logic [CNT_W-1:0]  cnt_comb;
    logic [CNT_W-1:0]  cnt_calc;
    logic [CNT_W-1:0]  cnt_out;
    logic [2:0]        err_sticky;
    logic [LW-1:0]     fifo_level;

    always #5 clk = ~clk;

    psinr_status_merge #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .arst_n(arst_n),
        .comb_status_tvalid(comb_status_tvalid), .comb_status_tdata(comb_status_tdata),
        .comb_status_tready(comb_status_tready),
        .psinr_calc_status_tvalid(psinr_calc_status_tvalid), .psinr_calc_status_tdata(psinr_calc_status_tdata),
        .psinr_calc_status_tready(psinr_calc_status_tready),
        .psinr_out_status_tvalid(psinr_out_status_tvalid), .psinr_out_status_tdata(psinr_out_status_tdata),
        .psinr_out_status_tready(psinr_out_status_tready),
        .m_status_tvalid(m_status_tvalid), .m_status_tdata(m_status_tdata),
        .m_status_tready(m_status_tready), .clr(clr),
        .cnt_comb(cnt_comb), .cnt_calc(cnt_calc), .cnt_out(cnt_out),
        .err_sticky(err_sticky), .fifo_level(fifo_level)
    );

    int checks = 0;
    int errors = 0;
    int unsigned gap_pct = 0;
    logic [2:0]  vld_on = '0;
    logic [11:0] pend0[$], pend1[$], pend2[$];
    logic [11:0] exp0[$], exp1[$], exp2[$];
    logic [15:0] out_q[$];
    int          model_cnt [3];
    logic [2:0]  model_err;

    // Reference model: accepted words per source, accepted-count since clear, OR of error bits.
    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            exp0.delete(); exp1.delete(); exp2.delete(); out_q.delete();
            for (int i = 0; i < 3; i++) model_cnt[i] <= 0;
            model_err <= '0;
        end else begin
            if (clr) begin
                model_cnt[0] <= (comb_status_tvalid && comb_status_tready) ? 1 : 0;
                model_cnt[1] <= (psinr_calc_status_tvalid && psinr_calc_status_tready) ? 1 : 0;
                model_cnt[2] <= (psinr_out_status_tvalid && psinr_out_status_tready) ? 1 : 0;
            end else begin
                if (comb_status_tvalid && comb_status_tready) model_cnt[0] <= model_cnt[0] + 1;
                if (psinr_calc_status_tvalid && psinr_calc_status_tready) model_cnt[1] <= model_cnt[1] + 1;
                if (psinr_out_status_tvalid && psinr_out_status_tready) model_cnt[2] <= model_cnt[2] + 1;
            end
            model_err <= (clr ? 3'b000 : model_err) |
                {psinr_out_status_tvalid && psinr_out_status_tready && psinr_out_status_tdata[0],
                 psinr_calc_status_tvalid && psinr_calc_status_tready && psinr_calc_status_tdata[0],
                 comb_status_tvalid && comb_status_tready && comb_status_tdata[0]};
            if (comb_status_tvalid && comb_status_tready) exp0.push_back(comb_status_tdata);
            if (psinr_calc_status_tvalid && psinr_calc_status_tready) exp1.push_back({2'b00, psinr_calc_status_tdata});
            if (psinr_out_status_tvalid && psinr_out_status_tready) exp2.push_back({5'b0, psinr_out_status_tdata});
            if (m_status_tvalid && m_status_tready) out_q.push_back(m_status_tdata);
        end
    end

    function automatic logic [CNT_W-1:0] sat(input int n);
        return (n > CNT_SAT) ? CNT_W'(CNT_SAT) : CNT_W'(n);
    endfunction

    function automatic logic [15:0] exp_word(input logic [1:0] tag);
        logic [15:0] w;
        w = 'x;
        if (tag == 2'd0 && exp0.size() > 0) w = {2'd0, 2'b00, exp0.pop_front()};
        if (tag == 2'd1 && exp1.size() > 0) w = {2'd1, 2'b00, exp1.pop_front()};
        if (tag == 2'd2 && exp2.size() > 0) w = {2'd2, 2'b00, exp2.pop_front()};
        return w;
    endfunction

    // One clock: present pending words (AXI-stable), sample handshakes, retire sent words.
    task automatic step(input logic do_clr);
        logic [2:0]  hs;
        logic [11:0] dmy;
        if (pend0.size() > 0 && (vld_on[0] || $urandom_range(99) >= gap_pct)) begin
            vld_on[0] = 1'b1; comb_status_tvalid = 1'b1; comb_status_tdata = pend0[0];
        end else comb_status_tvalid = 1'b0;
        if (pend1.size() > 0 && (vld_on[1] || $urandom_range(99) >= gap_pct)) begin
            vld_on[1] = 1'b1; psinr_calc_status_tvalid = 1'b1; psinr_calc_status_tdata = pend1[0][9:0];
        end else psinr_calc_status_tvalid = 1'b0;
        if (pend2.size() > 0 && (vld_on[2] || $urandom_range(99) >= gap_pct)) begin
            vld_on[2] = 1'b1; psinr_out_status_tvalid = 1'b1; psinr_out_status_tdata = pend2[0][6:0];
        end else psinr_out_status_tvalid = 1'b0;
        clr = do_clr;
        @(negedge clk);
        hs = {psinr_out_status_tvalid & psinr_out_status_tready,
              psinr_calc_status_tvalid & psinr_calc_status_tready,
              comb_status_tvalid & comb_status_tready};
        @(posedge clk);
        #1;
        clr = 1'b0;
        if (hs[0]) begin dmy = pend0.pop_front(); vld_on[0] = 1'b0; end
        if (hs[1]) begin dmy = pend1.pop_front(); vld_on[1] = 1'b0; end
        if (hs[2]) begin dmy = pend2.pop_front(); vld_on[2] = 1'b0; end
    endtask

    task automatic do_reset();
        pend0.delete(); pend1.delete(); pend2.delete();
        vld_on = '0;
        comb_status_tvalid = 1'b0; psinr_calc_status_tvalid = 1'b0; psinr_out_status_tvalid = 1'b0;
        arst_n = 1'b0;
        @(posedge clk);
        #1;
        arst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (m_status_tvalid !== 1'b0 || m_status_tdata !== 16'h0 || fifo_level !== '0) begin
            errors++;
            $display("FAIL reset_out: valid=%b data=%h level=%0d, required 0/0000/0", m_status_tvalid, m_status_tdata, fifo_level);
        end
        checks++;
        if (cnt_comb !== '0 || cnt_calc !== '0 || cnt_out !== '0 || err_sticky !== 3'b000) begin
            errors++;
            $display("FAIL reset_cnt: cnt=%0d/%0d/%0d err=%b, required 0/0/0 000", cnt_comb, cnt_calc, cnt_out, err_sticky);
        end
        checks++;
        if ({comb_status_tready, psinr_calc_status_tready, psinr_out_status_tready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_ready: treadys=%b%b%b, required 111", comb_status_tready, psinr_calc_status_tready, psinr_out_status_tready);
        end
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_single_word();
        logic [15:0] w, e;
        m_status_tready = 1'b1;
        pend0.push_back(12'h801);
        step(1'b0);
        checks++;
        if (cnt_comb !== sat(model_cnt[0]) || cnt_comb !== 4'd1 || err_sticky !== 3'b001) begin
            errors++;
            $display("FAIL single_cnt: cnt_comb=%0d err=%b, required 1 001", cnt_comb, err_sticky);
        end
        step(1'b0);
        checks++;
        if (m_status_tvalid !== 1'b1 || m_status_tdata !== 16'h0801) begin
            errors++;
            $display("FAIL single_latency: valid=%b data=%h, required 1 0801", m_status_tvalid, m_status_tdata);
        end
        repeat (3) step(1'b0);
        checks++;
        if (out_q.size() != 1) begin
            errors++;
            $display("FAIL single_count: words out=%0d, required 1", out_q.size());
        end
        while (out_q.size() > 0) begin
            w = out_q.pop_front(); e = exp_word(w[15:14]);
            checks++;
            if (w !== e) begin errors++; $display("FAIL single_data: got %h, required %h", w, e); end
        end
        $display("test_single_word done");
    endtask

    task automatic test_round_robin();
        logic [15:0] w, e;
        int k;
        do_reset();
        m_status_tready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pend0.push_back(12'($urandom));
            pend1.push_back(12'($urandom_range(1023)));
            pend2.push_back(12'($urandom_range(127)));
        end
        repeat (30) step(1'b0);
        checks++;
        if (out_q.size() != 18) begin
            errors++;
            $display("FAIL rr_count: words out=%0d, required 18", out_q.size());
        end
        k = 0;
        while (out_q.size() > 0) begin
            w = out_q.pop_front(); e = exp_word(w[15:14]);
            checks++;
            if (w[15:14] !== 2'(k % 3) || w !== e) begin
                errors++;
                $display("FAIL rr_word%0d: got %h, required tag %0d word %h", k, w, k % 3, e);
            end
            k++;
        end
        checks++;
        if (cnt_comb !== sat(model_cnt[0]) || cnt_calc !== sat(model_cnt[1]) || cnt_out !== sat(model_cnt[2]) || model_cnt[0] != 6) begin
            errors++;
            $display("FAIL rr_counts: cnt=%0d/%0d/%0d, required 6/6/6", cnt_comb, cnt_calc, cnt_out);
        end
        $display("test_round_robin done");
    endtask

    task automatic test_back_pressure();
        logic [15:0] w, e, held;
        m_status_tready = 1'b0;
        for (int i = 0; i < 10; i++) pend1.push_back(12'($urandom_range(1023)));
        repeat (15) step(1'b0);
        checks++;
        if (fifo_level !== LW'(FIFO_DEPTH) || psinr_calc_status_tready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full: level=%0d tready=%b, required %0d 0", fifo_level, psinr_calc_status_tready, FIFO_DEPTH);
        end
        checks++;
        if (exp1.size() != 9 || out_q.size() != 0) begin
            errors++;
            $display("FAIL bp_accepted: accepted=%0d out=%0d, required 9 0", exp1.size(), out_q.size());
        end
        held = m_status_tdata;
        step(1'b0);
        checks++;
        if (m_status_tdata !== held || m_status_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL bp_stable: data=%h valid=%b, required %h 1", m_status_tdata, m_status_tvalid, held);
        end
        m_status_tready = 1'b1;
        repeat (20) step(1'b0);
        while (out_q.size() > 0) begin
            w = out_q.pop_front(); e = exp_word(w[15:14]);
            checks++;
            if (w !== e) begin errors++; $display("FAIL bp_data: got %h, required %h", w, e); end
        end
        checks++;
        if (exp1.size() != 0 || pend1.size() != 0) begin
            errors++;
            $display("FAIL bp_loss: undelivered=%0d unsent=%0d, required 0 0", exp1.size(), pend1.size());
        end
        $display("test_back_pressure done");
    endtask

    task automatic test_saturation();
        logic [15:0] w, e;
        m_status_tready = 1'b1;
        for (int i = 0; i < 20; i++) pend2.push_back(12'($urandom_range(127)));
        for (int i = 0; i < 80 && pend2.size() > 0; i++) step(1'b0);
        checks++;
        if (pend2.size() != 0 || cnt_out !== sat(model_cnt[2]) || cnt_out !== 4'hF) begin
            errors++;
            $display("FAIL sat_reach: unsent=%0d cnt_out=%0d, required 0 15", pend2.size(), cnt_out);
        end
        for (int i = 0; i < 5; i++) pend2.push_back(12'($urandom_range(127)));
        repeat (10) step(1'b0);
        checks++;
        if (cnt_out !== 4'hF || err_sticky !== model_err) begin
            errors++;
            $display("FAIL sat_hold: cnt_out=%0d err=%b, required 15 %b", cnt_out, err_sticky, model_err);
        end
        while (out_q.size() > 0) begin
            w = out_q.pop_front(); e = exp_word(w[15:14]);
            checks++;
            if (w !== e) begin errors++; $display("FAIL sat_data: got %h, required %h", w, e); end
        end
        $display("test_saturation done");
    endtask

    task automatic test_clear_collision();
        logic [15:0] w, e;
        m_status_tready = 1'b1;
        pend0.push_back(12'h003); pend1.push_back(12'h002); pend2.push_back(12'h011);
        repeat (6) step(1'b0);
        checks++;
        if (err_sticky !== model_err || err_sticky[0] !== 1'b1 || err_sticky[2] !== 1'b1 || cnt_comb == '0) begin
            errors++;
            $display("FAIL clr_setup: err=%b cnt_comb=%0d, required %b nonzero", err_sticky, cnt_comb, model_err);
        end
        pend1.push_back(12'h001);
        step(1'b1);
        checks++;
        if (cnt_calc !== 4'd1 || cnt_comb !== 4'd0 || cnt_out !== 4'd0 || err_sticky !== 3'b010) begin
            errors++;
            $display("FAIL clr_collision: cnt=%0d/%0d/%0d err=%b, required 0/1/0 010", cnt_comb, cnt_calc, cnt_out, err_sticky);
        end
        repeat (4) step(1'b0);
        while (out_q.size() > 0) begin
            w = out_q.pop_front(); e = exp_word(w[15:14]);
            checks++;
            if (w !== e) begin errors++; $display("FAIL clr_data: got %h, required %h", w, e); end
        end
        $display("test_clear_collision done");
    endtask

    task automatic test_random();
        logic [15:0] w, e;
        int n;
        gap_pct = 30;
        n = $urandom_range(15, 5); for (int i = 0; i < n; i++) pend0.push_back(12'($urandom));
        n = $urandom_range(15, 5); for (int i = 0; i < n; i++) pend1.push_back(12'($urandom_range(1023)));
        n = $urandom_range(15, 5); for (int i = 0; i < n; i++) pend2.push_back(12'($urandom_range(127)));
        for (int i = 0; i < 400 && (pend0.size() + pend1.size() + pend2.size()) > 0; i++) begin
            m_status_tready = ($urandom_range(3) != 0);
            step(1'b0);
        end
        gap_pct = 0;
        m_status_tready = 1'b1;
        repeat (15) step(1'b0);
        while (out_q.size() > 0) begin
            w = out_q.pop_front(); e = exp_word(w[15:14]);
            checks++;
            if (w !== e) begin errors++; $display("FAIL rand_data: got %h, required %h", w, e); end
        end
        checks++;
        if (exp0.size() + exp1.size() + exp2.size() != 0 || pend0.size() + pend1.size() + pend2.size() != 0) begin
            errors++;
            $display("FAIL rand_loss: undelivered=%0d unsent=%0d, required 0 0",
                     exp0.size() + exp1.size() + exp2.size(), pend0.size() + pend1.size() + pend2.size());
        end
        checks++;
        if (cnt_comb !== sat(model_cnt[0]) || cnt_calc !== sat(model_cnt[1]) || cnt_out !== sat(model_cnt[2]) || err_sticky !== model_err) begin
            errors++;
            $display("FAIL rand_cnt: cnt=%0d/%0d/%0d err=%b, required %0d/%0d/%0d %b", cnt_comb, cnt_calc, cnt_out, err_sticky,
                     sat(model_cnt[0]), sat(model_cnt[1]), sat(model_cnt[2]), model_err);
        end
        $display("test_random done");
    endtask

    task automatic test_async_reset();
        logic [15:0] w, e;
        m_status_tready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pend0.push_back(12'($urandom)); pend1.push_back(12'($urandom_range(1023))); pend2.push_back(12'($urandom_range(127)));
        end
        for (int i = 0; i < 20 && fifo_level != LW'(5); i++) step(1'b0);
        checks++;
        if (fifo_level !== LW'(5)) begin
            errors++;
            $display("FAIL areset_setup: level=%0d, required 5", fifo_level);
        end
        #2;
        arst_n = 1'b0;
        #1;
        checks++;
        if (m_status_tvalid !== 1'b0 || m_status_tdata !== 16'h0 || fifo_level !== '0 ||
            cnt_comb !== '0 || cnt_calc !== '0 || cnt_out !== '0 || err_sticky !== 3'b000) begin
            errors++;
            $display("FAIL areset_now: valid=%b data=%h level=%0d cnt=%0d/%0d/%0d err=%b, required all 0",
                     m_status_tvalid, m_status_tdata, fifo_level, cnt_comb, cnt_calc, cnt_out, err_sticky);
        end
        checks++;
        if ({comb_status_tready, psinr_calc_status_tready, psinr_out_status_tready} !== 3'b111) begin
            errors++;
            $display("FAIL areset_ready: treadys=%b%b%b, required 111", comb_status_tready, psinr_calc_status_tready, psinr_out_status_tready);
        end
        do_reset();
        m_status_tready = 1'b1;
        repeat (5) step(1'b0);
        checks++;
        if (out_q.size() != 0 || m_status_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL areset_stale: words out=%0d valid=%b, required 0 0", out_q.size(), m_status_tvalid);
        end
        pend0.push_back(12'h5A4);
        repeat (4) step(1'b0);
        checks++;
        if (out_q.size() != 1) begin
            errors++;
            $display("FAIL areset_resume: words out=%0d, required 1", out_q.size());
        end
        while (out_q.size() > 0) begin
            w = out_q.pop_front(); e = exp_word(w[15:14]);
            checks++;
            if (w !== e || w !== 16'h05A4) begin errors++; $display("FAIL areset_data: got %h, required 05a4", w); end
        end
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_round_robin();
        test_back_pressure();
        test_saturation();
        test_clear_collision();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
